// File: rtl/scoreboard_regfile_if.sv
// rtl/scoreboard_regfile_if.sv - read, reserve, writeback and flush signals of the scoreboarded register file
interface scoreboard_regfile_if #(
  parameter int WORD = 32,
  parameter int NREG = 16,
  parameter int W_RD = $clog2(NREG)
);
  logic [W_RD-1:0] rd_name_i;
  logic [W_RD-1:0] rs_name_i;
  logic [WORD-1:0] rd_data_o;
  logic [WORD-1:0] rs_data_o;
  logic            rd_reserved_o;
  logic            rs_reserved_o;
  logic            rd_reserve_i;
  logic            rd_full_o;
  logic            wb0_i;
  logic [W_RD-1:0] wb0_name_i;
  logic [WORD-1:0] wb0_data_i;
  logic            wb1_i;
  logic [W_RD-1:0] wb1_name_i;
  logic [WORD-1:0] wb1_data_i;
  logic            flush_i;
  logic            busy_o;

  modport slave (
    input  rd_name_i, rs_name_i, rd_reserve_i,
    input  wb0_i, wb0_name_i, wb0_data_i,
    input  wb1_i, wb1_name_i, wb1_data_i,
    input  flush_i,
    output rd_data_o, rs_data_o, rd_reserved_o, rs_reserved_o, rd_full_o, busy_o
  );

  modport master (
    output rd_name_i, rs_name_i, rd_reserve_i,
    output wb0_i, wb0_name_i, wb0_data_i,
    output wb1_i, wb1_name_i, wb1_data_i,
    output flush_i,
    input  rd_data_o, rs_data_o, rd_reserved_o, rs_reserved_o, rd_full_o, busy_o
  );
endinterface

// File: rtl/scoreboard_regfile.sv
// rtl/scoreboard_regfile.sv - register file with per-register outstanding-write counters
// Optional same-cycle writeback bypass on the read ports: SCOREBOARD_REGFILE_BYPASS_EN.
module scoreboard_regfile #(
  parameter int WORD = 32,
  parameter int NREG = 16,
  parameter int W_RD = $clog2(NREG),
  parameter int CNTW = 2
) (
  input logic                clk,
  input logic                rst,
  scoreboard_regfile_if.slave bus
);
  localparam int CW1 = CNTW + 1;

  logic [WORD-1:0] regs    [NREG];
  logic [CNTW-1:0] cnt     [NREG];
  logic [CNTW-1:0] cnt_nxt [NREG];
  logic [CNTW-1:0] cnt_dec [NREG];
  logic            busy;

  // Net counter change: +1 for an accepted reserve, -1 per writeback port hit, floored at 0.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      logic [CW1-1:0] k;
      logic [CW1-1:0] up;
      logic           inc;
      k   = CW1'(bus.wb0_i && (bus.wb0_name_i == W_RD'(i)))
          + CW1'(bus.wb1_i && (bus.wb1_name_i == W_RD'(i)));
      inc = bus.rd_reserve_i && (bus.rd_name_i == W_RD'(i)) && (cnt[i] != {CNTW{1'b1}});
      up  = {1'b0, cnt[i]} + CW1'(inc);
      cnt_nxt[i] = (up > k) ? CNTW'(up - k) : '0;
      cnt_dec[i] = ({1'b0, cnt[i]} > k) ? CNTW'({1'b0, cnt[i]} - k) : '0;
      if (i == 0) begin
        cnt_nxt[i] = '0;
        cnt_dec[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
        cnt[i]  <= '0;
      end
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (bus.wb1_i && (bus.wb1_name_i == W_RD'(i))) begin
          regs[i] <= bus.wb1_data_i;
        end else if (bus.wb0_i && (bus.wb0_name_i == W_RD'(i))) begin
          regs[i] <= bus.wb0_data_i;
        end
        cnt[i] <= bus.flush_i ? '0 : cnt_nxt[i];
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      busy = busy | (cnt[i] != '0);
    end
  end

  // Both read ports share one path; index 0 is rd, index 1 is rs.
  always_comb begin
    logic [W_RD-1:0] name [2];
    logic [WORD-1:0] data [2];
    logic [CNTW-1:0] c    [2];
    name[0] = bus.rd_name_i;
    name[1] = bus.rs_name_i;
    for (int p = 0; p < 2; p++) begin
      data[p] = regs[name[p]];
`ifdef SCOREBOARD_REGFILE_BYPASS_EN
      c[p] = cnt_dec[name[p]];
      if (bus.wb0_i && (bus.wb0_name_i == name[p])) data[p] = bus.wb0_data_i;
      if (bus.wb1_i && (bus.wb1_name_i == name[p])) data[p] = bus.wb1_data_i;
`else
      c[p] = cnt[name[p]];
`endif
      if (rst || (name[p] == '0)) begin
        data[p] = '0;
        c[p]    = '0;
      end
    end
    bus.rd_data_o     = data[0];
    bus.rs_data_o     = data[1];
    bus.rd_reserved_o = (c[0] != '0);
    bus.rs_reserved_o = (c[1] != '0);
    bus.rd_full_o     = !rst && (cnt[bus.rd_name_i] == {CNTW{1'b1}});
    bus.busy_o        = !rst && busy;
  end
endmodule

// File: tb/tb_scoreboard_regfile.sv
// tb/tb_scoreboard_regfile.sv - randomized self-checking bench for scoreboard_regfile against an array model
module tb_scoreboard_regfile;
  localparam int MAXC = 3;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  logic [31:0] m_reg [16];
  int          m_cnt [16];

  scoreboard_regfile_if #(.WORD(32), .NREG(16)) sb ();

  scoreboard_regfile #(.WORD(32), .NREG(16), .CNTW(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
  endtask

  task automatic idle();
    sb.rd_name_i = '0; sb.rs_name_i = '0; sb.rd_reserve_i = 1'b0;
    sb.wb0_i = 1'b0; sb.wb0_name_i = '0; sb.wb0_data_i = '0;
    sb.wb1_i = 1'b0; sb.wb1_name_i = '0; sb.wb1_data_i = '0;
    sb.flush_i = 1'b0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      m_reg[i] = '0;
      m_cnt[i] = 0;
    end
  endtask

  function automatic int hits(input int n);
    return int'(sb.wb0_i && (int'(sb.wb0_name_i) == n)) + int'(sb.wb1_i && (int'(sb.wb1_name_i) == n));
  endfunction

  function automatic logic [31:0] exp_data(input int n);
    if (n == 0) return '0;
`ifdef SCOREBOARD_REGFILE_BYPASS_EN
    if (sb.wb1_i && int'(sb.wb1_name_i) == n) return sb.wb1_data_i;
    if (sb.wb0_i && int'(sb.wb0_name_i) == n) return sb.wb0_data_i;
`endif
    return m_reg[n];
  endfunction

  function automatic logic exp_resv(input int n);
    int c;
    if (n == 0) return 1'b0;
    c = m_cnt[n];
`ifdef SCOREBOARD_REGFILE_BYPASS_EN
    c = (c > hits(n)) ? c - hits(n) : 0;
`endif
    return c != 0;
  endfunction

  function automatic logic exp_busy();
    for (int i = 0; i < 16; i++) if (m_cnt[i] != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic compare_all();
    int rn, sn;
    rn = int'(sb.rd_name_i);
    sn = int'(sb.rs_name_i);
    check("rd_data",     sb.rd_data_o,            exp_data(rn));
    check("rs_data",     sb.rs_data_o,            exp_data(sn));
    check("rd_reserved", 32'(sb.rd_reserved_o),   32'(exp_resv(rn)));
    check("rs_reserved", 32'(sb.rs_reserved_o),   32'(exp_resv(sn)));
    check("rd_full",     32'(sb.rd_full_o),       32'(m_cnt[rn] == MAXC));
    check("busy",        32'(sb.busy_o),          32'(exp_busy()));
  endtask

  // Applies the inputs present at the clock edge to the model.
  task automatic model_update();
    int nc [16];
    for (int n = 1; n < 16; n++) begin
      int inc;
      inc = (sb.rd_reserve_i && int'(sb.rd_name_i) == n && m_cnt[n] < MAXC) ? 1 : 0;
      nc[n] = m_cnt[n] + inc - hits(n);
      if (nc[n] < 0) nc[n] = 0;
      if (sb.flush_i) nc[n] = 0;
    end
    for (int n = 1; n < 16; n++) m_cnt[n] = nc[n];
    if (sb.wb0_i && sb.wb0_name_i != 0) m_reg[sb.wb0_name_i] = sb.wb0_data_i;
    if (sb.wb1_i && sb.wb1_name_i != 0) m_reg[sb.wb1_name_i] = sb.wb1_data_i;
  endtask

  task automatic settle();
    #3;
    compare_all();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  task automatic reserve(input int n);
    idle(); sb.rd_reserve_i = 1'b1; sb.rd_name_i = 4'(n);
    step();
  endtask

  task automatic wb0(input int n, input logic [31:0] d);
    idle(); sb.wb0_i = 1'b1; sb.wb0_name_i = 4'(n); sb.wb0_data_i = d;
    step();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    model_clear();
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // Outputs stay quiet under reset even with live writeback traffic.
    sb.rd_name_i = 4'd5; sb.rs_name_i = 4'd9; sb.rd_reserve_i = 1'b1;
    sb.wb0_i = 1'b1; sb.wb0_name_i = 4'd5; sb.wb0_data_i = 32'h1111_2222;
    sb.wb1_i = 1'b1; sb.wb1_name_i = 4'd9; sb.wb1_data_i = 32'h3333_4444;
    @(posedge clk); #2;
    check("rst_rd_data",  sb.rd_data_o, 32'h0);
    check("rst_rs_data",  sb.rs_data_o, 32'h0);
    check("rst_rd_resv",  32'(sb.rd_reserved_o), 32'h0);
    check("rst_rs_resv",  32'(sb.rs_reserved_o), 32'h0);
    check("rst_full",     32'(sb.rd_full_o), 32'h0);
    check("rst_busy",     32'(sb.busy_o), 32'h0);
    @(posedge clk); #1;
    idle();
    rst = 1'b0;

    wb0(5, 32'hDEADBEEF);
    idle(); sb.rd_name_i = 4'd5;
    settle();
    check("r5_data", sb.rd_data_o, 32'hDEADBEEF);
    check("r5_resv", 32'(sb.rd_reserved_o), 32'h0);
    tick();

    for (int i = 0; i < 3; i++) reserve(3);
    idle(); sb.rd_name_i = 4'd3;
    settle();
    check("r3_full", 32'(sb.rd_full_o), 32'h1);
    tick();
    reserve(3);
    check("r3_cnt_sat", 32'(m_cnt[3]), 32'(MAXC));
    for (int i = 0; i < 3; i++) begin
      wb0(3, 32'(i));
      idle(); sb.rd_name_i = 4'd3;
      settle();
      check("r3_resv_drain", 32'(sb.rd_reserved_o), (i == 2) ? 32'h0 : 32'h1);
      tick();
    end

    reserve(7);
    reserve(7);
    idle();
    sb.wb0_i = 1'b1; sb.wb0_name_i = 4'd7; sb.wb0_data_i = 32'h11;
    sb.wb1_i = 1'b1; sb.wb1_name_i = 4'd7; sb.wb1_data_i = 32'h22;
    step();
    idle(); sb.rd_name_i = 4'd7;
    settle();
    check("r7_data", sb.rd_data_o, 32'h22);
    check("r7_resv", 32'(sb.rd_reserved_o), 32'h0);
    tick();

    wb0(4, 32'h1234);
    idle(); sb.wb0_i = 1'b1; sb.wb0_name_i = 4'd4; sb.wb0_data_i = 32'hA5; sb.rs_name_i = 4'd4;
    settle();
`ifdef SCOREBOARD_REGFILE_BYPASS_EN
    check("r4_bypass", sb.rs_data_o, 32'hA5);
`else
    check("r4_nobypass", sb.rs_data_o, 32'h1234);
`endif
    tick();

    reserve(2);
    idle(); sb.rd_reserve_i = 1'b1; sb.rd_name_i = 4'd6; sb.flush_i = 1'b1;
    step();
    idle(); sb.rd_name_i = 4'd6; sb.rs_name_i = 4'd2;
    settle();
    check("flush_busy", 32'(sb.busy_o), 32'h0);
    check("flush_r6",   32'(sb.rd_reserved_o), 32'h0);
    check("flush_r2",   32'(sb.rs_reserved_o), 32'h0);
    tick();

    idle(); sb.wb0_i = 1'b1; sb.wb0_name_i = 4'd0; sb.wb0_data_i = 32'hFFFF;
    sb.rd_reserve_i = 1'b1; sb.rd_name_i = 4'd0;
    step();
    idle();
    settle();
    check("r0_data", sb.rd_data_o, 32'h0);
    check("r0_resv", 32'(sb.rd_reserved_o), 32'h0);
    check("r0_busy", 32'(sb.busy_o), 32'h0);
    tick();

    for (int cyc = 0; cyc < 400; cyc++) begin
      sb.rd_name_i    = 4'($urandom_range(0, 15));
      sb.rs_name_i    = 4'($urandom_range(0, 15));
      sb.rd_reserve_i = ($urandom_range(0, 1) == 1);
      sb.wb0_i        = ($urandom_range(0, 9) < 4);
      sb.wb0_name_i   = 4'($urandom_range(0, 7));
      sb.wb0_data_i   = $urandom;
      sb.wb1_i        = ($urandom_range(0, 9) < 4);
      sb.wb1_name_i   = 4'($urandom_range(0, 7));
      sb.wb1_data_i   = $urandom;
      sb.flush_i      = ($urandom_range(0, 39) == 0);
      if (sb.rd_reserve_i && $urandom_range(0, 1) == 1) sb.rd_name_i = 4'($urandom_range(0, 7));
      step();
    end

    // Asynchronous reset in the middle of a cycle clears state before any edge.
    reserve(9);
    reserve(10);
    idle(); sb.rd_name_i = 4'd9; sb.rs_name_i = 4'd10;
    #2;
    rst = 1'b1;
    #1;
    model_clear();
    check("arst_busy",  32'(sb.busy_o), 32'h0);
    check("arst_rd",    32'(sb.rd_reserved_o), 32'h0);
    check("arst_rs",    32'(sb.rs_reserved_o), 32'h0);
    check("arst_data",  sb.rd_data_o, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/scoreboard_regfile.md
SCOREBOARD_REGFILE -- requirements
Module: scoreboard_regfile

Interface
REQ-001 Parameter WORD, default 32, register data width in bits.
REQ-002 Parameter NREG, default 16, number of architectural registers; power of two, at least 4.
REQ-003 Parameter W_RD, default log2(NREG), register-name width.
REQ-004 Parameter CNTW, default 2, width of each per-register outstanding-write counter.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 rd_name_i, rs_name_i  input  W_RD each  read-port register names.
REQ-008 rd_data_o, rs_data_o  output  WORD each  read-port data.
REQ-009 rd_reserved_o, rs_reserved_o  output  1 each  high when the named register has outstanding writes.
REQ-010 rd_reserve_i  input  1  reserves the register named by rd_name_i, incrementing its counter by 1.
REQ-011 rd_full_o  output  1  high when the counter for rd_name_i equals 2^CNTW-1.
REQ-012 wb0_i, wb0_name_i, wb0_data_i  input  1/W_RD/WORD  writeback port 0 (execute stage).
REQ-013 wb1_i, wb1_name_i, wb1_data_i  input  1/W_RD/WORD  writeback port 1 (memory stage).
REQ-014 flush_i  input  1  synchronously clears all counters.
REQ-015 busy_o  output  1  high when any counter is nonzero.

Function
REQ-016 Register 0 SHALL always read 0, ignore writes, and never report reserved; reserve and writeback to it are ignored.
REQ-017 Reads SHALL be combinational from the register array and the counter array.
REQ-018 A write on wbN_i SHALL update the register at the clock edge; the new value is visible on the next cycle.
REQ-019 If wb0 and wb1 name the same register in one cycle, the register SHALL take wb1_data_i.
REQ-020 Each valid writeback SHALL decrement the named counter by 1; if both ports hit one register, it SHALL decrement by 2. A counter SHALL never go below 0; a decrement at 0 is ignored.
REQ-021 Reserve and writeback to the same register in one cycle SHALL apply the net change: +1 and -k, with k being the number of writeback ports hitting that register.
REQ-022 rd_reserve_i while rd_full_o is high SHALL be ignored, with the counter unchanged; the issuing stage must stall on rd_full_o.
REQ-023 *_reserved_o SHALL equal (counter != 0) for the named register.
REQ-024 flush_i SHALL zero all counters at the edge and override reserve and decrement in that cycle; register writes in the same cycle still occur.
REQ-025 busy_o SHALL be the OR of all counters being nonzero, evaluated from registered state.

Reset
REQ-026 While rst is high: all registers are 0, all counters are 0, and busy_o, rd_reserved_o, rs_reserved_o and rd_full_o are 0.
REQ-027 While rst is high, rd_data_o and rs_data_o read 0.
REQ-028 Reset asserted mid-operation SHALL discard all pending reservations and writes immediately, without waiting for a clock edge.

Configuration
REQ-029 Macro SCOREBOARD_REGFILE_BYPASS_EN defined: a read whose name matches a same-cycle valid writeback SHALL return that writeback's data (wb1 over wb0). For that read, *_reserved_o SHALL reflect the counter after the decrement.
REQ-030 Macro not defined: reads return the stored array value only, and *_reserved_o reflects the registered counter.

Verification
REQ-031 After reset, write 0xDEADBEEF to r5 via wb0, then read r5 next cycle -> rd_data_o=0xDEADBEEF and rd_reserved_o=0.
REQ-032 Reserve r3 three times with CNTW=2 -> rd_full_o=1 after the third reserve; a fourth reserve is ignored; three wb0 writes to r3 -> reserved clears after the third.
REQ-033 Same cycle: wb0 writes r7=0x11, wb1 writes r7=0x22, counter was 2 -> next cycle r7=0x22 and counter=0.
REQ-034 With the bypass macro: wb0 writes r4=0xA5 while rs_name_i=4 -> rs_data_o=0xA5 in the same cycle. Without the macro -> the old value is returned in that cycle.
REQ-035 Reserve r2, then assert flush_i together with a reserve of r6 -> next cycle busy_o=0 and no register is reserved.
REQ-036 Write r0=0xFFFF and reserve r0 -> r0 reads 0, rd_reserved_o=0 and busy_o=0.
